// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-capture block.
// Holds the default 640x480@60 timing constants, the frame-buffer address width, the
// counter width and the state encodings of the lock and capture FSMs.
package vga_pkg;

  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_TOTAL  = 525;
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_START  = 144;
  localparam int unsigned V_START  = 35;

  localparam int unsigned ADDR_W = 19;
  localparam int unsigned CNT_W  = 10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    LkSearch,
    LkVerify,
    LkLocked
  } lock_state_e;

  typedef enum logic [1:0] {
    CapIdle,
    CapArmed,
    CapCapture
  } cap_state_e;

  // Increment that sticks at the counter maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (val == CNT_MAX) ? val : val + 1'b1;
  endfunction

endpackage

// File: rtl/vga_sync_detect.sv
// Input registering, sync edge detection, h/v position counters and the lock FSM.
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   h_sync_i        horizontal sync (active low), v_sync_i vertical sync (active low)
//   pixel_i         raw pixel {B,G,R}
//   pixel_o         registered pixel matching active_o/frame_start_o
//   active_o        registered pixel lies inside the active window
//   frame_start_o   this cycle is the first line of a new frame
//   lock_ok_o       locked and no timing error detected this cycle
//   locked_o        lock FSM is in LOCKED
//   timing_err_o    one-cycle pulse on a timing mismatch while locked
module vga_sync_detect
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned H_START  = vga_pkg::H_START,
  parameter int unsigned V_START  = vga_pkg::V_START,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync_i,
  input  logic        v_sync_i,
  input  logic [11:0] pixel_i,
  output logic [11:0] pixel_o,
  output logic        active_o,
  output logic        frame_start_o,
  output logic        lock_ok_o,
  output logic        locked_o,
  output logic        timing_err_o
);

  localparam logic [CNT_W-1:0] HLast  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] VLast  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HActLo = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HActHi = CNT_W'(H_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VActLo = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VActHi = CNT_W'(V_START + V_ACTIVE - 1);

  logic             hs_q, vs_q, hs_prev_q, vs_line_q;
  logic [11:0]      pix_q;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  lock_state_e      state_q, state_d;
  logic             err_q, err_d;
  logic             line_start, frame_start, h_bad, v_bad, h_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_q     <= '0;
      hs_prev_q <= 1'b0;
      vs_line_q <= 1'b0;
      h_q       <= '0;
      v_q       <= '0;
    end else begin
      hs_q      <= h_sync_i;
      vs_q      <= v_sync_i;
      pix_q     <= pixel_i;
      hs_prev_q <= hs_q;
      // v_sync level seen at the most recent line start, for frame-edge detection
      if (line_start) vs_line_q <= vs_q;
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // h_d/v_d are the position of the pixel currently held in pix_q; h_q/v_q the
  // position of the previous cycle, so h_q at a line start is the last count of that line.
  always_comb begin
    line_start  = hs_prev_q & ~hs_q;
    frame_start = line_start & ~vs_q & vs_line_q;
    h_d         = line_start ? '0 : sat_inc(h_q);
    v_d         = v_q;
    if (frame_start)     v_d = '0;
    else if (line_start) v_d = sat_inc(v_q);
    h_bad   = line_start & (h_q != HLast);
    v_bad   = frame_start & (v_q != VLast);
    h_stall = ~line_start & (h_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LkSearch;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LkSearch: if (frame_start) state_d = LkVerify;
      LkVerify: begin
        if (h_bad || v_bad || h_stall) state_d = LkSearch;
        else if (frame_start)          state_d = LkLocked;
      end
      LkLocked: if (h_bad || v_bad || h_stall) state_d = LkSearch;
      default:  state_d = LkSearch;
    endcase
  end

  always_comb begin
    err_d     = (state_q == LkLocked) & (h_bad | v_bad | h_stall);
    lock_ok_o = (state_q == LkLocked) & ~err_d;
    locked_o  = (state_q == LkLocked);
  end

  assign timing_err_o  = err_q;
  assign pixel_o       = pix_q;
  assign frame_start_o = frame_start;
  assign active_o      = (h_d >= HActLo) & (h_d <= HActHi) & (v_d >= VActLo) & (v_d <= VActHi);

endmodule

// File: rtl/vga_capture.sv
// Single-frame VGA capture into a linear frame buffer.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   h_sync, v_sync      active-low syncs; pixel_data {B,G,R} 4 bits each
//   cap_req             one-cycle request to capture the next locked frame
//   cap_busy            capture armed or in progress; cap_done one-cycle completion pulse
//   wr_en/wr_addr/wr_data  frame-buffer write port, address row*H_ACTIVE+col
//   locked              input timing matches; timing_err one-cycle mismatch pulse
module vga_capture
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL  = vga_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL  = vga_pkg::V_TOTAL,
  parameter int unsigned H_START  = vga_pkg::H_START,
  parameter int unsigned V_START  = vga_pkg::V_START,
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_sync,
  input  logic              v_sync,
  input  logic [11:0]       pixel_data,
  input  logic              cap_req,
  output logic              cap_busy,
  output logic              cap_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              locked,
  output logic              timing_err
);

  localparam logic [ADDR_W-1:0] AddrLast = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

  logic [11:0]       pix;
  logic              active, frame_start, lock_ok;
  cap_state_e        cap_q, cap_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, cur_addr;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [11:0]       wr_data_q;
  logic              wr_en_q, done_q;
  logic              start_cap, wr_fire, last_pending;

  vga_sync_detect #(
    .H_TOTAL (H_TOTAL),
    .V_TOTAL (V_TOTAL),
    .H_START (H_START),
    .V_START (V_START),
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE)
  ) u_sync (
    .clk          (clk),
    .rst          (rst),
    .h_sync_i     (h_sync),
    .v_sync_i     (v_sync),
    .pixel_i      (pixel_data),
    .pixel_o      (pix),
    .active_o     (active),
    .frame_start_o(frame_start),
    .lock_ok_o    (lock_ok),
    .locked_o     (locked),
    .timing_err_o (timing_err)
  );

  always_ff @(posedge clk) begin
    if (rst) cap_q <= CapIdle;
    else     cap_q <= cap_d;
  end

  // Leave CAPTURE one cycle after the final write becomes visible, so cap_busy
  // falls in the same cycle cap_done rises.
  always_comb begin
    cap_d = cap_q;
    unique case (cap_q)
      CapIdle:  if (cap_req) cap_d = CapArmed;
      CapArmed: if (frame_start && lock_ok) cap_d = CapCapture;
      CapCapture: begin
        if (last_pending)  cap_d = CapIdle;
        else if (!lock_ok) cap_d = CapArmed;
      end
      default: cap_d = CapIdle;
    endcase
  end

  always_comb begin
    last_pending = wr_en_q & (wr_addr_q == AddrLast);
    start_cap    = (cap_q == CapArmed) & frame_start & lock_ok;
    wr_fire      = ((cap_q == CapCapture) | start_cap) & lock_ok & active & ~last_pending;
    cur_addr     = start_cap ? '0 : cnt_q;
    cnt_d        = cnt_q;
    if (start_cap) cnt_d = '0;
    if (wr_fire)   cnt_d = cur_addr + 1'b1;
    cap_busy     = (cap_q != CapIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_en_q <= wr_fire;
      if (wr_fire) begin
        wr_addr_q <= cur_addr;
        wr_data_q <= pix;
      end
      done_q <= last_pending;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cap_done = done_q;

endmodule
